// File: rtl/key_schedule_pkg.sv
// Shared definitions for the AES-128 key schedule: FSM encoding, round constants
// and the Rcon table.
package key_schedule_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ksState_e;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_WORDS  = 4;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Entry 0 is unused; Rcon[r] feeds the top byte of word 0 in round r.
  localparam logic [10:0][7:0] RCON = {
    8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10,
    8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  function automatic logic [7:0] rconFor(input logic [3:0] idx);
    logic [7:0] value;
    if (idx <= LAST_ROUND) begin
      value = RCON[idx];
    end else begin
      value = 8'h00;
    end
    return value;
  endfunction

endpackage

// File: rtl/key_schedule_sbox.sv
// Forward AES S-box for one byte: multiplicative inverse in GF(2^8) followed by
// the affine transform.
module key_sbox
  import key_schedule_pkg::*;
(
  input  logic [7:0] inByte,
  output logic [7:0] outByte
);

  function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) begin
        p = p ^ a;
      end else begin
        p = p;
      end
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the inverse for nonzero x and maps 0 to 0, as the S-box needs.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x6   = gfMul(x3, x3);
    x12  = gfMul(x6, x6);
    x15  = gfMul(x12, x3);
    x30  = gfMul(x15, x15);
    x60  = gfMul(x30, x30);
    x120 = gfMul(x60, x60);
    x240 = gfMul(x120, x120);
    return gfMul(gfMul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Substitution of a single byte
  always_comb begin
    outByte = affine(gfInv(inByte));
  end

endmodule

// File: rtl/key_schedule.sv
// AES-128 key expansion, one round key per cycle into an 11-entry store with a
// zero-latency combinational read port.
module key_schedule
  import key_schedule_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic [3:0]   memadd,
  output logic [127:0] roundkey,
  output logic         key_busy,
  output logic         key_valid
);

  ksState_e     state_r, nextState_s;
  logic [3:0]   cnt_r;
  logic [127:0] store_r [0:NUM_ROUNDS];
  logic         busy_r, valid_r;
  logic         loadEn_s, stepEn_s, lastStep_s;
  logic [127:0] prevKey_s, nextKey_s;
  logic [31:0]  rotWord_s, subWord_s, temp_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and datapath control; loads are only honoured outside EXPAND
  always_comb begin
    nextState_s = state_r;
    loadEn_s    = 1'b0;
    stepEn_s    = 1'b0;
    lastStep_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (key_load) begin
          loadEn_s    = 1'b1;
          nextState_s = EXPAND;
        end else begin
          nextState_s = state_r;
        end
      end
      EXPAND: begin
        stepEn_s = 1'b1;
        if (cnt_r == LAST_ROUND) begin
          lastStep_s  = 1'b1;
          nextState_s = DONE;
        end else begin
          nextState_s = EXPAND;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Previous round key, guarded so an idle counter never indexes out of range
  always_comb begin
    if ((cnt_r != 4'd0) && (cnt_r <= LAST_ROUND)) begin
      prevKey_s = store_r[cnt_r - 4'd1];
    end else begin
      prevKey_s = 128'h0;
    end
  end

  assign rotWord_s = {prevKey_s[23:0], prevKey_s[31:24]};

  for (genvar g = 0; g < KEY_WORDS; g++) begin : gSubWord
    key_sbox uSbox (
      .inByte  (rotWord_s[8*g +: 8]),
      .outByte (subWord_s[8*g +: 8])
    );
  end

  // One FIPS-197 expansion round: chained XOR across the four words
  always_comb begin
    temp_s    = subWord_s ^ {rconFor(cnt_r), 24'h000000};
    w0_s      = prevKey_s[127:96] ^ temp_s;
    w1_s      = prevKey_s[95:64]  ^ w0_s;
    w2_s      = prevKey_s[63:32]  ^ w1_s;
    w3_s      = prevKey_s[31:0]   ^ w2_s;
    nextKey_s = {w0_s, w1_s, w2_s, w3_s};
  end

  // Key store, round counter and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        store_r[i] <= 128'h0;
      end
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (loadEn_s) begin
      store_r[0] <= key_in;
      cnt_r      <= 4'd1;
      busy_r     <= 1'b1;
      valid_r    <= 1'b0;
    end else if (stepEn_s) begin
      store_r[cnt_r] <= nextKey_s;
      cnt_r          <= cnt_r + 4'd1;
      if (lastStep_s) begin
        busy_r  <= 1'b0;
        valid_r <= 1'b1;
      end else begin
        busy_r  <= busy_r;
        valid_r <= valid_r;
      end
    end else begin
      cnt_r   <= cnt_r;
      busy_r  <= busy_r;
      valid_r <= valid_r;
    end
  end

  // Zero-latency read; nothing is visible until a full schedule is stored
  always_comb begin
    if (valid_r && (memadd <= LAST_ROUND)) begin
      roundkey = store_r[memadd];
    end else begin
      roundkey = 128'h0;
    end
  end

  assign key_busy  = busy_r;
  assign key_valid = valid_r;

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: directed FIPS-197 vectors plus random
// loads/resets compared against a word-level key-expansion model.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_load;
  logic [3:0]   memadd;
  logic [127:0] roundkey;
  logic         key_busy;
  logic         key_valid;

  always #5 clk = ~clk;

  key_schedule dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_load  (key_load),
    .memadd    (memadd),
    .roundkey  (roundkey),
    .key_busy  (key_busy),
    .key_valid (key_valid)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0]   sbox  [0:255];
  logic [127:0] mKeys [0:10];
  logic [127:0] mPend [0:10];
  logic         mValid;
  int           mBusyLeft;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int tbMul(input int a, input int b);
    int r = 0;
    int aa = a;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) r = r ^ aa;
      aa = aa << 1;
      if (aa & 'h100) aa = aa ^ 'h11B;
    end
    return r;
  endfunction

  // S-box from its definition: brute-force inverse, then bitwise affine map.
  task automatic buildSbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && tbMul(x, y) == 1) inv = y[7:0];
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox[x] = s;
    end
  endtask

  task automatic expandModel(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mPend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic modelEdge(input logic rst, input logic load, input logic [127:0] k);
    if (rst) begin
      mValid = 1'b0;
      mBusyLeft = 0;
      for (int a = 0; a < 11; a++) mKeys[a] = 128'h0;
    end else if (mBusyLeft > 0) begin
      mBusyLeft--;
      if (mBusyLeft == 0) begin
        mValid = 1'b1;
        for (int a = 0; a < 11; a++) mKeys[a] = mPend[a];
      end
    end else if (load) begin
      expandModel(k);
      mBusyLeft = 10;
      mValid = 1'b0;
    end
  endtask

  function automatic logic [127:0] modelRead(input int addr);
    return (mValid && addr <= 10) ? mKeys[addr] : 128'h0;
  endfunction

  task automatic step(input logic rst, input logic load, input logic [127:0] k);
    reset = rst;
    key_load = load;
    key_in = k;
    @(posedge clk);
    modelEdge(rst, load, k);
    #1;
    reset = 1'b0;
    key_load = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic checkState(input string tag);
    checkVal({tag, " busy"}, key_busy, mBusyLeft > 0);
    checkVal({tag, " valid"}, key_valid, mValid);
    checkVal({tag, " exclusive"}, key_busy & key_valid, 1'b0);
    memadd = 4'($urandom_range(0, 15));
    #1;
    checkVal({tag, " roundkey"}, roundkey, modelRead(memadd));
  endtask

  task automatic readAt(input string tag, input int addr, input logic [127:0] exp);
    memadd = addr[3:0];
    #1;
    checkVal(tag, roundkey, exp);
  endtask

  logic [127:0] keyA;

  initial begin
    reset = 1'b1;
    key_load = 1'b0;
    key_in = 128'h0;
    memadd = 4'd0;
    mValid = 1'b0;
    mBusyLeft = 0;
    for (int a = 0; a < 11; a++) mKeys[a] = 128'h0;
    buildSbox();

    step(1'b1, 1'b0, 128'h0);
    step(1'b1, 1'b0, 128'h0);
    checkState("reset");
    readAt("reset rk0", 0, 128'h0);

    // FIPS-197 vector: valid exactly 10 edges after the load edge
    step(1'b0, 1'b1, FIPS_KEY);
    checkVal("fips load busy", key_busy, 1'b1);
    checkVal("fips load valid", key_valid, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 1'b0, 128'h0);
      checkVal("fips valid timing", key_valid, (c == 10));
      checkVal("fips busy timing", key_busy, (c < 10));
    end
    readAt("fips rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    readAt("fips rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readAt("fips rk0", 0, FIPS_KEY);
    readAt("fips rk11", 11, 128'h0);
    readAt("fips rk15", 15, 128'h0);
    for (int a = 0; a < 11; a++) readAt("fips model", a, modelRead(a));

    // Second load during EXPAND must be ignored
    keyA = {$urandom, $urandom, $urandom, $urandom};
    step(1'b0, 1'b1, keyA);
    for (int c = 1; c <= 10; c++) begin
      checkVal("ignore busy", key_busy, 1'b1);
      step(1'b0, (c == 4), {$urandom, $urandom, $urandom, $urandom});
    end
    checkState("ignore done");
    readAt("ignore rk0", 0, keyA);
    for (int a = 0; a < 11; a++) readAt("ignore model", a, modelRead(a));

    // Reset at cycle 5 of EXPAND aborts the expansion
    step(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    for (int c = 1; c <= 4; c++) step(1'b0, 1'b0, 128'h0);
    step(1'b1, 1'b0, 128'h0);
    checkVal("abort busy", key_busy, 1'b0);
    checkVal("abort valid", key_valid, 1'b0);
    for (int a = 0; a < 16; a++) readAt("abort rk", a, 128'h0);
    step(1'b0, 1'b0, 128'h0);
    checkVal("abort stays idle", key_busy, 1'b0);

    // Reset wins over key_load on the same edge
    step(1'b1, 1'b1, FIPS_KEY);
    checkVal("rst+load busy", key_busy, 1'b0);
    checkVal("rst+load valid", key_valid, 1'b0);
    step(1'b0, 1'b0, 128'h0);
    checkVal("rst+load no start", key_busy, 1'b0);

    // Reload from DONE with the all-zero key
    step(1'b0, 1'b1, FIPS_KEY);
    for (int c = 1; c <= 10; c++) step(1'b0, 1'b0, 128'h0);
    checkVal("reload pre valid", key_valid, 1'b1);
    step(1'b0, 1'b1, 128'h0);
    checkVal("reload drop valid", key_valid, 1'b0);
    readAt("reload old hidden", 1, 128'h0);
    for (int c = 1; c <= 10; c++) step(1'b0, 1'b0, 128'h0);
    readAt("zero key rk1", 1, 128'h62636363626363636263636362636363);
    readAt("zero key rk10", 10, modelRead(10));

    // Random loads, resets and reads against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
           {$urandom, $urandom, $urandom, $urandom});
      checkState("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
